// File: rtl/dice_result_stabilizer_pkg.sv
// Shared class codes, FSM state type and counter sizing for the dice result stabilizer.
package dice_pkg;

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_R    = 2'd1;
    localparam logic [1:0] CLS_G    = 2'd2;
    localparam logic [1:0] CLS_B    = 2'd3;

    typedef enum logic [1:0] {
        S_LOCK = 2'd0,
        S_ARM  = 2'd1,
        S_EMIT = 2'd2
    } stab_state_t;

    // Width that holds the larger of two frame-count limits without wrapping.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/dice_result_stabilizer_if.sv
// Frame-count inputs and dice-result outputs between the camera path, stabilizer and game FSM.
interface dice_result_stabilizer_if #(
    parameter int CNT_W = 17
);
    logic             frame_done;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_g;
    logic [CNT_W-1:0] cnt_b;
    logic             dice_valid;
    logic [1:0]       dice_value;
    logic [1:0]       cand_value;
    logic             locked;

    modport master (
        output frame_done, cnt_r, cnt_g, cnt_b,
        input  dice_valid, dice_value, cand_value, locked
    );

    modport slave (
        input  frame_done, cnt_r, cnt_g, cnt_b,
        output dice_valid, dice_value, cand_value, locked
    );
endinterface

// File: rtl/dice_result_stabilizer_frame_classifier.sv
// Picks the dominant colour of a finished frame (ties favour R, then G) and
// registers its class code together with a one-cycle strobe.
module frame_classifier
    import dice_pkg::*;
#(
    parameter int CNT_W      = 17,
    parameter int PIX_THRESH = 2000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_done,
    input  logic [CNT_W-1:0] cnt_r,
    input  logic [CNT_W-1:0] cnt_g,
    input  logic [CNT_W-1:0] cnt_b,
    output logic             class_stb,
    output logic [1:0]       class_code
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(PIX_THRESH);

    logic [CNT_W-1:0] win_cnt_s;
    logic [1:0]       win_code_s;
    logic [1:0]       class_s;

    // Winner selection and threshold test.
    always_comb begin
        win_cnt_s  = cnt_r;
        win_code_s = CLS_R;
        class_s    = CLS_NONE;
        if ((cnt_r >= cnt_g) && (cnt_r >= cnt_b)) begin
            win_cnt_s  = cnt_r;
            win_code_s = CLS_R;
        end else if (cnt_g >= cnt_b) begin
            win_cnt_s  = cnt_g;
            win_code_s = CLS_G;
        end else begin
            win_cnt_s  = cnt_b;
            win_code_s = CLS_B;
        end
        if (win_cnt_s >= THRESH_C) begin
            class_s = win_code_s;
        end else begin
            class_s = CLS_NONE;
        end
    end

    // Classification output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            class_stb  <= 1'b0;
            class_code <= CLS_NONE;
        end else begin
            class_stb <= frame_done;
            if (frame_done) begin
                class_code <= class_s;
            end else begin
                class_code <= class_code;
            end
        end
    end

endmodule

// File: rtl/dice_result_stabilizer.sv
// Accepts one dice roll once a colour class is stable for STABLE_FRAMES frames,
// then stays locked until CLEAR_FRAMES consecutive empty frames are seen.
module dice_result_stabilizer
    import dice_pkg::*;
#(
    parameter int CNT_W         = 17,
    parameter int PIX_THRESH    = 2000,
    parameter int STABLE_FRAMES = 8,
    parameter int CLEAR_FRAMES  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    dice_result_stabilizer_if.slave  bus
);

    localparam int            CW       = cnt_width(STABLE_FRAMES, CLEAR_FRAMES);
    localparam logic [CW-1:0] STAB_C   = CW'(STABLE_FRAMES);
    localparam logic [CW-1:0] CLR_C    = CW'(CLEAR_FRAMES);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    logic        class_stb_s;
    logic [1:0]  class_code_s;

    stab_state_t state_r, state_nxt_s;
    logic [CW-1:0] clr_cnt_r, clr_nxt_s, clr_upd_s;
    logic [CW-1:0] stab_cnt_r, stab_nxt_s, stab_upd_s;
    logic [1:0]  cand_r, cand_nxt_s, cand_upd_s;
    logic        dice_valid_r;
    logic [1:0]  dice_value_r;
    logic        locked_r;

    frame_classifier #(
        .CNT_W      (CNT_W),
        .PIX_THRESH (PIX_THRESH)
    ) u_classifier (
        .clk        (clk),
        .reset      (reset),
        .frame_done (bus.frame_done),
        .cnt_r      (bus.cnt_r),
        .cnt_g      (bus.cnt_g),
        .cnt_b      (bus.cnt_b),
        .class_stb  (class_stb_s),
        .class_code (class_code_s)
    );

    // Next-state and counter update, evaluated once per classified frame.
    always_comb begin
        state_nxt_s = state_r;
        clr_nxt_s   = clr_cnt_r;
        stab_nxt_s  = stab_cnt_r;
        cand_nxt_s  = cand_r;
        clr_upd_s   = clr_cnt_r;
        stab_upd_s  = stab_cnt_r;
        cand_upd_s  = cand_r;
        case (state_r)
            S_LOCK: begin
                if (class_stb_s) begin
                    if (class_code_s != CLS_NONE) begin
                        clr_upd_s = CNT_ZERO;
                    end else if (clr_cnt_r < CLR_C) begin
                        clr_upd_s = clr_cnt_r + CNT_ONE;
                    end else begin
                        clr_upd_s = clr_cnt_r;
                    end
                    if (clr_upd_s == CLR_C) begin
                        state_nxt_s = S_ARM;
                        clr_nxt_s   = CNT_ZERO;
                        stab_nxt_s  = CNT_ZERO;
                        cand_nxt_s  = CLS_NONE;
                    end else begin
                        clr_nxt_s = clr_upd_s;
                    end
                end else begin
                    clr_nxt_s = clr_cnt_r;
                end
            end
            S_ARM: begin
                if (class_stb_s) begin
                    // An empty frame breaks the run but keeps the candidate for the LED.
                    if (class_code_s == CLS_NONE) begin
                        stab_upd_s = CNT_ZERO;
                        cand_upd_s = cand_r;
                    end else if ((class_code_s == cand_r) && (stab_cnt_r != CNT_ZERO)) begin
                        stab_upd_s = (stab_cnt_r < STAB_C) ? (stab_cnt_r + CNT_ONE) : stab_cnt_r;
                        cand_upd_s = cand_r;
                    end else begin
                        stab_upd_s = CNT_ONE;
                        cand_upd_s = class_code_s;
                    end
                    stab_nxt_s = stab_upd_s;
                    cand_nxt_s = cand_upd_s;
                    if (stab_upd_s == STAB_C) begin
                        state_nxt_s = S_EMIT;
                    end else begin
                        state_nxt_s = S_ARM;
                    end
                end else begin
                    state_nxt_s = S_ARM;
                end
            end
            S_EMIT: begin
                state_nxt_s = S_LOCK;
                clr_nxt_s   = CNT_ZERO;
            end
            default: begin
                state_nxt_s = S_LOCK;
                clr_nxt_s   = CNT_ZERO;
                stab_nxt_s  = CNT_ZERO;
                cand_nxt_s  = CLS_NONE;
            end
        endcase
    end

    // State, counters and output registers; outputs follow the next state so
    // dice_valid is high exactly during the S_EMIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_LOCK;
            clr_cnt_r    <= CNT_ZERO;
            stab_cnt_r   <= CNT_ZERO;
            cand_r       <= CLS_NONE;
            dice_valid_r <= 1'b0;
            dice_value_r <= CLS_NONE;
            locked_r     <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            clr_cnt_r    <= clr_nxt_s;
            stab_cnt_r   <= stab_nxt_s;
            cand_r       <= cand_nxt_s;
            dice_valid_r <= (state_nxt_s == S_EMIT);
            locked_r     <= (state_nxt_s == S_LOCK);
            if (state_nxt_s == S_EMIT) begin
                dice_value_r <= cand_nxt_s;
            end else begin
                dice_value_r <= dice_value_r;
            end
        end
    end

    assign bus.dice_valid = dice_valid_r;
    assign bus.dice_value = dice_value_r;
    assign bus.cand_value = cand_r;
    assign bus.locked     = locked_r;

endmodule

// File: tb/tb_dice_result_stabilizer.sv
// Self-checking bench: directed roll scenarios plus random bursts, compared
// cycle by cycle against a frame-history reference model.
module tb_dice_result_stabilizer;

    localparam int CNT_W = 17;
    localparam int TH    = 2000;
    localparam int SF    = 8;
    localparam int CF    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dice_result_stabilizer_if #(.CNT_W(CNT_W)) bus ();

    dice_result_stabilizer #(
        .CNT_W(CNT_W), .PIX_THRESH(TH), .STABLE_FRAMES(SF), .CLEAR_FRAMES(CF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    typedef struct {
        int valid;
        int locked;
        int value;
        int cand;
    } snap_t;

    // Reference model: classes seen since the last lock/arm event.
    int    hist[$];
    int    m_locked;
    int    m_cand;
    int    m_value;
    snap_t s1, s2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int classify(input int r, input int g, input int b);
        int best;
        int code;
        best = r; code = 1;
        if (g > best) begin best = g; code = 2; end
        if (b > best) begin best = b; code = 3; end
        return (best >= TH) ? code : 0;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s.valid = 0; s.locked = 1; s.value = 0; s.cand = 0;
        return s;
    endfunction

    function automatic void model_reset();
        hist.delete();
        m_locked = 1; m_cand = 0; m_value = 0;
    endfunction

    // Returns 1 when this frame completes a stable run.
    function automatic int model_frame(input int cls);
        int all_zero;
        int run;
        hist.push_back(cls);
        if (m_locked != 0) begin
            all_zero = (hist.size() >= CF);
            for (int i = 0; i < CF && i < hist.size(); i++)
                if (hist[hist.size()-1-i] != 0) all_zero = 0;
            if (all_zero != 0) begin
                m_locked = 0; m_cand = 0; hist.delete();
            end
            return 0;
        end
        if (cls == 0) return 0;
        m_cand = cls;
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == cls; i--) run++;
        if (run >= SF) begin
            m_value = cls; hist.delete();
            return 1;
        end
        return 0;
    endfunction

    // One clock cycle: check outputs against the model two cycles back, then drive.
    task automatic step(input bit fd, input int r, input int g, input int b, output int emit);
        @(posedge clk); #1;
        check_eq("dice_valid", bus.dice_valid, s2.valid);
        check_eq("locked", bus.locked, s2.locked);
        check_eq("dice_value", bus.dice_value, s2.value);
        check_eq("cand_value", bus.cand_value, s2.cand);
        if (bus.dice_valid === 1'b1) pulses++;
        s2 = s1;
        bus.frame_done = fd;
        bus.cnt_r = r[CNT_W-1:0];
        bus.cnt_g = g[CNT_W-1:0];
        bus.cnt_b = b[CNT_W-1:0];
        emit = fd ? model_frame(classify(r, g, b)) : 0;
        s1.valid  = emit;
        s1.locked = (emit != 0) ? 0 : m_locked;
        s1.value  = m_value;
        s1.cand   = m_cand;
        if (emit != 0) m_locked = 1;
    endtask

    task automatic idle(input int n);
        int e;
        repeat (n) step(1'b0, 0, 0, 0, e);
    endtask

    // n frames with random spacing; never a frame in the cycle right after an emitting one.
    task automatic frames(input int n, input int r, input int g, input int b);
        int e;
        int gap;
        for (int i = 0; i < n; i++) begin
            step(1'b1, r, g, b, e);
            gap = $urandom_range(0, 2);
            if (e != 0 && gap < 1) gap = 1;
            idle(gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.frame_done = 1'b0;
        bus.cnt_r = '0; bus.cnt_g = '0; bus.cnt_b = '0;
        #1;
        check_eq("rst_dice_valid", bus.dice_valid, 0);
        check_eq("rst_dice_value", bus.dice_value, 0);
        check_eq("rst_cand_value", bus.cand_value, 0);
        check_eq("rst_locked", bus.locked, 1);
        model_reset();
        s1 = reset_snap();
        s2 = reset_snap();
        @(negedge clk);
        reset = 1'b0;
    endtask

    int p0;
    int kind;
    int rr, gg, bb;

    initial begin
        bus.frame_done = 1'b0;
        bus.cnt_r = '0; bus.cnt_g = '0; bus.cnt_b = '0;
        model_reset();
        s1 = reset_snap();
        s2 = reset_snap();
        do_reset();

        // Die present at power-up never fires; clearing then re-presenting does.
        p0 = pulses;
        frames(20, 5000, 0, 0);
        idle(3);
        check_eq("pwrup_locked", bus.locked, 1);
        check_eq("pwrup_no_pulse", pulses - p0, 0);
        frames(4, 0, 0, 0);
        idle(3);
        check_eq("pwrup_armed", bus.locked, 0);
        frames(8, 5000, 0, 0);
        idle(4);
        check_eq("pwrup_pulse", pulses - p0, 1);
        check_eq("pwrup_value", bus.dice_value, 1);

        // Flicker restarts the run.
        frames(4, 0, 0, 0);
        p0 = pulses;
        frames(5, 0, 4000, 0);
        frames(1, 0, 0, 4000);
        frames(7, 0, 4000, 0);
        idle(3);
        check_eq("flicker_no_pulse", pulses - p0, 0);
        frames(1, 0, 4000, 0);
        idle(4);
        check_eq("flicker_pulse", pulses - p0, 1);
        check_eq("flicker_value", bus.dice_value, 2);

        // Threshold boundary.
        frames(4, 0, 0, 0);
        p0 = pulses;
        frames(30, 0, 0, 1999);
        idle(3);
        check_eq("below_cand", bus.cand_value, 0);
        check_eq("below_no_pulse", pulses - p0, 0);
        frames(8, 0, 0, 2000);
        idle(4);
        check_eq("thresh_pulse", pulses - p0, 1);
        check_eq("thresh_value", bus.dice_value, 3);

        // Ties resolve R > G > B.
        frames(4, 0, 0, 0);
        frames(8, 3000, 3000, 0);
        idle(4);
        check_eq("tie_rg_value", bus.dice_value, 1);
        frames(4, 0, 0, 0);
        frames(8, 0, 3000, 3000);
        idle(4);
        check_eq("tie_gb_value", bus.dice_value, 2);

        // Lockout: only a full run of clear frames re-arms.
        p0 = pulses;
        frames(50, 5000, 0, 0);
        frames(3, 0, 0, 0);
        frames(1, 5000, 0, 0);
        frames(3, 0, 0, 0);
        idle(3);
        check_eq("lockout_no_pulse", pulses - p0, 0);
        check_eq("lockout_still_locked", bus.locked, 1);
        frames(1, 0, 0, 0);
        idle(3);
        check_eq("lockout_rearmed", bus.locked, 0);

        // Reset in the middle of a stable run cancels it.
        p0 = pulses;
        frames(7, 5000, 0, 0);
        do_reset();
        frames(1, 5000, 0, 0);
        idle(4);
        check_eq("midrst_no_pulse", pulses - p0, 0);
        check_eq("midrst_locked", bus.locked, 1);

        // Random bursts of repeated patterns.
        for (int k = 0; k < 80; k++) begin
            kind = $urandom_range(0, 5);
            rr = $urandom_range(0, 1990);
            gg = $urandom_range(0, 1990);
            bb = $urandom_range(0, 1990);
            case (kind)
                1: rr = $urandom_range(1995, 6000);
                2: gg = $urandom_range(1995, 6000);
                3: bb = $urandom_range(1995, 6000);
                4: begin rr = $urandom_range(1995, 4000); gg = rr; bb = ($urandom_range(0, 1) != 0) ? rr : bb; end
                5: begin gg = $urandom_range(1995, 4000); bb = gg; end
                default: ;
            endcase
            frames($urandom_range(1, 11), rr, gg, bb);
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
